// File: rtl/seven_segment_pkg.sv
// Shared glyph table, FSM state type and nibble-to-segment helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seven_segment_pkg;

    // Segment order is {dp,g,f,e,d,c,b,a}, active high.
    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seven_segment_mux_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter with sticky overflow.
// Latency: VALUE_BITS cycles from start; done pulses during the last shift cycle.
// Backpressure: none; start is only honoured by the caller while busy is low.
module bin_to_bcd #(
    parameter int VALUE_BITS = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    start,
    input  logic [VALUE_BITS-1:0]   value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int BCD_BITS = 4 * NUM_DIGITS;
    localparam int CNT_W    = $clog2(VALUE_BITS + 1);

    logic [VALUE_BITS-1:0] sh_q;
    logic [BCD_BITS-1:0]   bcd_q;
    logic [BCD_BITS-1:0]   adj;
    logic [CNT_W-1:0]      cnt_q;
    logic                  busy_q;
    logic                  ovf_q;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (start) begin
            sh_q   <= value;
            bcd_q  <= '0;
            cnt_q  <= CNT_W'(VALUE_BITS);
            busy_q <= 1'b1;
            ovf_q  <= 1'b0;
        end else if (busy_q) begin
            // Anything leaving the top nibble means the value needs more digits.
            sh_q   <= sh_q << 1;
            bcd_q  <= {adj[BCD_BITS-2:0], sh_q[VALUE_BITS-1]};
            ovf_q  <= ovf_q | adj[BCD_BITS-1];
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt_q == CNT_W'(1));
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver: hex/decimal glyphs, blanking, dp, overflow dashes.
// Latency: hex write visible after 1 busy cycle, decimal after VALUE_BITS+1; outputs 1 cycle behind scan.
// Backpressure: writes are dropped while o_busy is high; no queueing.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int VALUE_BITS   = 8,
    parameter int COUNTER_BITS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [VALUE_BITS-1:0] i_value,
    input  logic                  i_we,
    input  logic                  i_mode,
    input  logic                  i_blank_lz,
    input  logic [NUM_DIGITS-1:0] i_dp,
    input  logic                  i_oe,
    output logic                  o_busy,
    output logic [7:0]            o_data,
    output logic [NUM_DIGITS-1:0] o_addr
);

    localparam int BCD_BITS = 4 * NUM_DIGITS;
    localparam int EXT_BITS = (VALUE_BITS > BCD_BITS) ? VALUE_BITS : BCD_BITS;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t state_q, state_nxt;
    logic   conv_start, buf_we;

    logic [VALUE_BITS-1:0] val_q;
    logic                  mode_q;
    logic                  blz_q;
    logic [NUM_DIGITS-1:0] dp_q;

    logic                conv_busy, conv_done, conv_ovf;
    logic [BCD_BITS-1:0] conv_bcd;

    logic [EXT_BITS-1:0] val_ext;
    logic                hex_ovf;
    logic                any_ovf;
    logic                lz_run;
    logic                blank;
    logic [3:0]          nib;
    logic [7:0]          glyph;
    logic [7:0]          seg_nxt   [NUM_DIGITS];
    logic [7:0]          disp_buf_q[NUM_DIGITS];

    logic [COUNTER_BITS-1:0] scan_cnt_q;
    logic [IDX_W-1:0]        cur_q;
    logic                    cur_legal;
    logic [NUM_DIGITS-1:0]   addr_nxt;

    bin_to_bcd #(
        .VALUE_BITS (VALUE_BITS),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin_to_bcd (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .start    (conv_start),
        .value    (i_value),
        .busy     (conv_busy),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        conv_start = 1'b0;
        buf_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_we) begin
                    conv_start = i_mode;
                    state_nxt  = i_mode ? ST_SHIFT : ST_COMMIT;
                end
            end
            ST_SHIFT: begin
                if (conv_done || !conv_busy) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                buf_we    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy = (state_q != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            val_q  <= '0;
            mode_q <= 1'b0;
            blz_q  <= 1'b0;
            dp_q   <= '0;
        end else if ((state_q == ST_IDLE) && i_we) begin
            val_q  <= i_value;
            mode_q <= i_mode;
            blz_q  <= i_blank_lz;
            dp_q   <= i_dp;
        end
    end

    assign val_ext = EXT_BITS'(val_q);

    always_comb begin
        hex_ovf = 1'b0;
        for (int i = BCD_BITS; i < VALUE_BITS; i++) begin
            hex_ovf = hex_ovf | val_q[i];
        end
    end

    assign any_ovf = mode_q ? conv_ovf : hex_ovf;

    // Walk from the most significant digit so the zero run is known per digit.
    always_comb begin
        lz_run = 1'b1;
        blank  = 1'b0;
        nib    = '0;
        glyph  = SEG_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_nxt[k] = SEG_BLANK;
        end
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib    = mode_q ? conv_bcd[4*k +: 4] : val_ext[4*k +: 4];
            lz_run = lz_run && (nib == 4'd0);
            blank  = blz_q && lz_run && (k != 0);
            if (any_ovf) begin
                glyph = SEG_DASH;
            end else if (blank) begin
                glyph = SEG_BLANK;
            end else begin
                glyph = hex_to_seg(nib);
            end
            seg_nxt[k] = glyph | {dp_q[k], 7'b0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                disp_buf_q[k] <= SEG_BLANK;
            end
        end else if (buf_we) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                disp_buf_q[k] <= seg_nxt[k];
            end
        end
    end

    assign cur_legal = (32'(cur_q) < 32'(NUM_DIGITS));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scan_cnt_q <= '0;
            cur_q      <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_q + COUNTER_BITS'(1);
            if (!cur_legal) begin
                cur_q <= '0;
            end else if (&scan_cnt_q) begin
                cur_q <= (cur_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : cur_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        addr_nxt = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            addr_nxt[k] = (32'(cur_q) == 32'(k));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_addr <= '0;
            o_data <= '0;
        end else begin
            o_addr <= addr_nxt;
            o_data <= (i_oe && cur_legal) ? disp_buf_q[cur_q] : 8'h00;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: three instances cover 8-bit/3-digit,
// 12-bit/3-digit and 12-bit/2-digit configurations with a short scan prescaler.
module tb_seven_segment_mux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [11:0] value;
    logic        we_a, we_b, we_c;
    logic        mode, blz, oe;
    logic [2:0]  dp;

    logic        busy_a, busy_b, busy_c;
    logic [7:0]  data_a, data_b, data_c;
    logic [2:0]  addr_a, addr_b;
    logic [1:0]  addr_c;

    int n_tests = 0;
    int n_fail  = 0;

    seven_segment_mux #(.NUM_DIGITS(3), .VALUE_BITS(8), .COUNTER_BITS(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value[7:0]), .i_we(we_a),
        .i_mode(mode), .i_blank_lz(blz), .i_dp(dp), .i_oe(oe),
        .o_busy(busy_a), .o_data(data_a), .o_addr(addr_a)
    );

    seven_segment_mux #(.NUM_DIGITS(3), .VALUE_BITS(12), .COUNTER_BITS(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_we(we_b),
        .i_mode(mode), .i_blank_lz(blz), .i_dp(dp), .i_oe(oe),
        .o_busy(busy_b), .o_data(data_b), .o_addr(addr_b)
    );

    seven_segment_mux #(.NUM_DIGITS(2), .VALUE_BITS(12), .COUNTER_BITS(4)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_we(we_c),
        .i_mode(mode), .i_blank_lz(blz), .i_dp(dp[1:0]), .i_oe(oe),
        .o_busy(busy_c), .o_data(data_c), .o_addr(addr_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_busy(input int w);
        return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic [2:0] sel_addr(input int w);
        return (w == 0) ? addr_a : (w == 1) ? addr_b : {1'b0, addr_c};
    endfunction

    function automatic logic [7:0] sel_data(input int w);
        return (w == 0) ? data_a : (w == 1) ? data_b : data_c;
    endfunction

    task automatic do_write(input int w, input logic [11:0] v, input logic md,
                            input logic lz, input logic [2:0] d, output int busy_cycles);
        @(negedge clk);
        value = v; mode = md; blz = lz; dp = d;
        we_a = (w == 0); we_b = (w == 1); we_c = (w == 2);
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
        busy_cycles = 0;
        while (sel_busy(w) && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_addr(input int w, input logic [2:0] a, input string tag);
        int t;
        t = 0;
        while (sel_addr(w) !== a && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_scan_timeout"}, 32'(t < 100), 32'd1);
    endtask

    // Reads every digit through the scanned outputs, digit 0 in the low byte.
    task automatic capture(input int w, input int nd, input string tag, output logic [23:0] disp);
        logic [2:0] a;
        disp = '0;
        @(negedge clk);
        for (int k = 0; k < nd; k++) begin
            a = 3'b001 << k;
            wait_addr(w, a, tag);
            disp[8*k +: 8] = sel_data(w);
        end
    endtask

    initial begin
        logic [23:0] disp;
        int          bc;
        int          run;

        rst_n = 1'b0; value = '0; mode = 1'b0; blz = 1'b0; dp = '0; oe = 1'b1;
        we_a = 1'b0; we_b = 1'b0; we_c = 1'b0;
        #2;
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_data", 32'(data_a), 32'h00);
        check("reset_addr", 32'(addr_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        capture(0, 3, "reset_buf", disp);
        check("reset_buf", 32'(disp), 32'h000000);

        // Decimal 123
        do_write(0, 12'd123, 1'b1, 1'b0, 3'b000, bc);
        check("dec123_busy", 32'(bc), 32'd9);
        capture(0, 3, "dec123", disp);
        check("dec123_buf", 32'(disp), 32'h065B4F);
        wait_addr(0, 3'b001, "dwell");
        wait_addr(0, 3'b010, "dwell");
        run = 0;
        while (addr_a === 3'b010 && run < 100) begin
            run++;
            @(negedge clk);
        end
        check("dwell_len", 32'(run), 32'd16);
        check("dwell_next_addr", 32'(addr_a), 32'b100);
        check("dwell_next_data", 32'(data_a), 32'h06);

        // Leading-zero blanking with decimal point
        do_write(0, 12'd7, 1'b1, 1'b1, 3'b100, bc);
        capture(0, 3, "dec7_lz", disp);
        check("dec7_lz_buf", 32'(disp), 32'h800007);
        do_write(0, 12'd7, 1'b1, 1'b0, 3'b000, bc);
        capture(0, 3, "dec7_nolz", disp);
        check("dec7_nolz_buf", 32'(disp), 32'h3F3F07);
        do_write(0, 12'd255, 1'b1, 1'b1, 3'b000, bc);
        capture(0, 3, "dec255", disp);
        check("dec255_buf", 32'(disp), 32'h5B6D6D);

        // Hex mode
        do_write(0, 12'h0AF, 1'b0, 1'b1, 3'b000, bc);
        check("hexAF_busy", 32'(bc), 32'd1);
        capture(0, 3, "hexAF", disp);
        check("hexAF_buf", 32'(disp), 32'h007771);
        do_write(0, 12'h000, 1'b0, 1'b1, 3'b000, bc);
        capture(0, 3, "hex00", disp);
        check("hex00_buf", 32'(disp), 32'h00003F);

        // Overflow and wider values
        do_write(1, 12'd1234, 1'b1, 1'b0, 3'b000, bc);
        check("dec1234_busy", 32'(bc), 32'd13);
        capture(1, 3, "dec1234", disp);
        check("dec1234_buf", 32'(disp), 32'h404040);
        do_write(1, 12'h1AB, 1'b0, 1'b0, 3'b000, bc);
        capture(1, 3, "hex1AB", disp);
        check("hex1AB_buf", 32'(disp), 32'h06777C);
        do_write(2, 12'hFFF, 1'b0, 1'b0, 3'b000, bc);
        capture(2, 2, "hexFFF", disp);
        check("hexFFF_buf", 32'(disp), 32'h004040);

        // Back-to-back writes: second one lands while busy and is dropped
        @(negedge clk);
        value = 12'd45; mode = 1'b1; blz = 1'b0; dp = 3'b000; we_a = 1'b1;
        @(negedge clk);
        check("b2b_busy", 32'(busy_a), 32'd1);
        value = 12'd99;
        @(negedge clk);
        we_a = 1'b0;
        bc = 0;
        while (busy_a && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        capture(0, 3, "b2b", disp);
        check("b2b_buf", 32'(disp), 32'h3F666D);

        // Output enable low blanks segments while the scan keeps rotating
        oe = 1'b0;
        @(negedge clk); @(negedge clk);
        wait_addr(0, 3'b001, "oe0");
        check("oe0_d0", 32'(data_a), 32'h00);
        wait_addr(0, 3'b010, "oe0");
        check("oe0_d1", 32'(data_a), 32'h00);
        wait_addr(0, 3'b100, "oe0");
        check("oe0_d2", 32'(data_a), 32'h00);
        wait_addr(0, 3'b001, "oe0");
        check("oe0_d0b", 32'(data_a), 32'h00);
        oe = 1'b1;

        // Reset in the middle of a conversion
        @(negedge clk);
        value = 12'd200; mode = 1'b1; blz = 1'b0; dp = 3'b000; we_a = 1'b1;
        @(negedge clk); we_a = 1'b0;
        @(negedge clk); @(negedge clk);
        check("midrst_busy_before", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_data", 32'(data_a), 32'h00);
        check("midrst_addr", 32'(addr_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("postrst_addr", 32'(addr_a), 32'b001);
        check("postrst_data", 32'(data_a), 32'h00);
        do_write(0, 12'd200, 1'b1, 1'b0, 3'b000, bc);
        check("dec200_busy", 32'(bc), 32'd9);
        capture(0, 3, "dec200", disp);
        check("dec200_buf", 32'(disp), 32'h5B3F3F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
